uart_tx_arbiter: RTL

- Shares one uart_tx serializer among NREQ byte requesters using round-robin arbitration.
- Each requester offers a byte with a valid/ready handshake.
- The arbiter latches the winning byte, pulses tx_start, and holds tx_din until uart_tx returns tx_done_tick.
- Sits between the per-channel TX FIFOs and the single uart_tx + timer_input baud pair.

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter and related UART blocks.
package uart_pkg;

  localparam int DBIT_DEFAULT = 8;
  localparam int NREQ_MAX     = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority encoder: first set request at or after ptr_i.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // ptr_i is always below N, so one conditional subtraction performs the wrap.
  always_comb begin
    int cand;
    cand  = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte requesters.
// Optional packet locking is enabled with the macro UART_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DBIT  = DBIT_DEFAULT,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NREQ-1:0]      req_lock,
`endif
  output logic [NREQ-1:0]      req_ready,
  output logic                 tx_start,
  output logic [DBIT-1:0]      tx_din,
  input  logic                 tx_done_tick,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [DBIT-1:0]  tx_din_q, tx_din_d;

  logic [NREQ-1:0]  pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic [NREQ-1:0]  win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic [DBIT-1:0]  win_data;

`ifdef UART_ARB_LOCK_EN
  logic             lock_valid_q, lock_valid_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
`endif

  rr_pick #(
    .N  (NREQ),
    .IW (IDX_W)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // A locked owner that is still valid overrides the round-robin choice.
  always_comb begin
    win_onehot = pick_gnt;
    win_idx    = pick_idx;
    win_any    = pick_any;
`ifdef UART_ARB_LOCK_EN
    if (lock_valid_q && req_valid[lock_idx_q]) begin
      win_onehot             = '0;
      win_onehot[lock_idx_q] = 1'b1;
      win_idx                = lock_idx_q;
      win_any                = 1'b1;
    end
`endif
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDX_W'(i)) win_data = req_data[i*DBIT +: DBIT];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    tx_din_d    = tx_din_q;
    req_ready   = '0;
    tx_start    = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock_valid_d = lock_valid_q;
    lock_idx_d   = lock_idx_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef UART_ARB_LOCK_EN
        if (lock_valid_q && !req_valid[lock_idx_q]) lock_valid_d = 1'b0;
`endif
        if (win_any) begin
          req_ready   = win_onehot;
          tx_din_d    = win_data;
          grant_idx_d = win_idx;
          state_d     = START;
`ifdef UART_ARB_LOCK_EN
          lock_valid_d = req_lock[win_idx];
          lock_idx_d   = win_idx;
`endif
        end
      end
      START: begin
        tx_start = 1'b1;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done_tick) begin
          state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
          if (!lock_valid_q)
`endif
          rr_ptr_d = (grant_idx_q == IDX_W'(NREQ - 1)) ? '0 : grant_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      tx_din_q    <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_valid_q <= 1'b0;
      lock_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      tx_din_q    <= tx_din_d;
`ifdef UART_ARB_LOCK_EN
      lock_valid_q <= lock_valid_d;
      lock_idx_q   <= lock_idx_d;
`endif
    end
  end

  assign tx_din    = tx_din_q;
  assign grant_idx = grant_idx_q;
  assign busy      = (state_q != IDLE);

endmodule
